// File: rtl/sparse_pkg.sv
// ----------------------------------------------------------------------------
// sparse_pkg
// Shared constants for the sparse datapath: the index generator geometry and
// the crossbar lane/select types that consume its output. Keeping them side by
// side keeps the generator lane count and the crossbar width in step.
// ----------------------------------------------------------------------------
package sparse_pkg;

    // Index generator defaults
    localparam int SP_NUM_IN = 8;
    localparam int SP_DW_IDX = $clog2(SP_NUM_IN);
    localparam int SP_DW_NNZ = 16;

    // Crossbar: one lane per input position, each lane selects a source index
    typedef logic [SP_DW_IDX-1:0]               xbar_sel_t;
    typedef logic [SP_NUM_IN-1:0][SP_DW_IDX-1:0] xbar_ctl_t;
    typedef logic [SP_NUM_IN-1:0]               xbar_lane_en_t;

endpackage

// File: rtl/prefix_cnt.sv
// ----------------------------------------------------------------------------
// prefix_cnt
// Exclusive prefix popcount of a bitmap: pfx[i] is the number of set bits in
// mask[i-1:0], so a set bit i lands on compacted lane pfx[i].
// Purely combinational.
//
// Ports
//   mask  in   NUM_IN            bitmap
//   pfx   out  NUM_IN x DW_IDX+1 exclusive prefix count per position
// ----------------------------------------------------------------------------
module prefix_cnt
    import sparse_pkg::*;
#(
    parameter int NUM_IN = SP_NUM_IN,
    parameter int DW_IDX = SP_DW_IDX
) (
    input  logic [NUM_IN-1:0]           mask,
    output logic [NUM_IN-1:0][DW_IDX:0] pfx
);

    localparam int CW = DW_IDX + 1;

    logic [CW-1:0] run;

    always_comb begin
        run = '0;
        pfx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            pfx[i] = run;
            run    = run + CW'(mask[i]);
        end
    end

endmodule

// File: rtl/sparse_idx_gen.sv
// ----------------------------------------------------------------------------
// sparse_idx_gen
// Turns a nonzero bitmap into crossbar control: lane j receives the position
// of the (j+1)-th set bit. Two-stage valid/ready pipeline, plus a per-tile
// nonzero accumulator reported when the last mask of a tile leaves.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready input handshake; in_mask bitmap, in_last tile end
//   out_valid/out_ready output handshake
//   out_idx           lane j source index at [j*DW_IDX +: DW_IDX]
//   out_lane_vld      lane j carries a real nonzero
//   out_cnt           popcount of the mask
//   out_last          in_last carried through
//   tile_nnz          nonzero total of the last completed tile (saturating)
//   tile_done         one-cycle pulse when tile_nnz updates
// ----------------------------------------------------------------------------
module sparse_idx_gen
    import sparse_pkg::*;
#(
    parameter int NUM_IN = SP_NUM_IN,
    parameter int DW_IDX = SP_DW_IDX,
    parameter int DW_NNZ = SP_DW_NNZ
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_IN-1:0]        in_mask,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_IN*DW_IDX-1:0] out_idx,
    output logic [NUM_IN-1:0]        out_lane_vld,
    output logic [DW_IDX:0]          out_cnt,
    output logic                     out_last,
    output logic [DW_NNZ-1:0]        tile_nnz,
    output logic                     tile_done
);

    localparam int CW = DW_IDX + 1;
    localparam int SW = ((DW_NNZ > CW) ? DW_NNZ : CW) + 1;

    function automatic logic [DW_NNZ-1:0] sat_add(input logic [DW_NNZ-1:0] a,
                                                  input logic [CW-1:0]     b);
        logic [SW-1:0] sum;
        sum = SW'(a) + SW'(b);
        if (|sum[SW-1:DW_NNZ])
            return '1;
        return sum[DW_NNZ-1:0];
    endfunction

    logic                      vld_p1, vld_p2;
    logic                      s1_ready, s2_ready;
    logic                      in_fire, out_fire;
    logic [NUM_IN-1:0][CW-1:0] pfx_c, pfx_p1;
    logic [NUM_IN-1:0]         mask_p1;
    logic                      last_p1;
    logic [NUM_IN*DW_IDX-1:0]  idx_c;
    logic [NUM_IN-1:0]         lane_vld_c;
    logic [CW-1:0]             cnt_c;
    logic [DW_NNZ-1:0]         acc, acc_nxt;

    assign s2_ready  = !vld_p2 || out_ready;
    assign s1_ready  = !vld_p1 || s2_ready;
    // Reset forces both handshake outputs low combinationally.
    assign in_ready  = rst_n && s1_ready;
    assign out_valid = rst_n && vld_p2;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // ---- Stage 1: register mask, last flag and exclusive prefix counts ----
    prefix_cnt #(
        .NUM_IN (NUM_IN),
        .DW_IDX (DW_IDX)
    ) u_prefix_cnt (
        .mask (in_mask),
        .pfx  (pfx_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else if (s1_ready)
            vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            mask_p1 <= in_mask;
            last_p1 <= in_last;
            pfx_p1  <= pfx_c;
        end
    end

    // ---- Stage 2: compact into lanes, register idx/lane_vld/cnt/last ----
    always_comb begin
        idx_c      = '0;
        lane_vld_c = '0;
        for (int j = 0; j < NUM_IN; j++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (mask_p1[i] && (pfx_p1[i] == CW'(j))) begin
                    idx_c[j*DW_IDX +: DW_IDX] = DW_IDX'(i);
                    lane_vld_c[j]             = 1'b1;
                end
            end
        end
        cnt_c = pfx_p1[NUM_IN-1] + CW'(mask_p1[NUM_IN-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2       <= 1'b0;
            out_idx      <= '0;
            out_lane_vld <= '0;
            out_cnt      <= '0;
            out_last     <= 1'b0;
        end else if (s2_ready) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_idx      <= idx_c;
                out_lane_vld <= lane_vld_c;
                out_cnt      <= cnt_c;
                out_last     <= last_p1;
            end
        end
    end

    // ---- Tile accumulator: sums beats as they leave, reports on last ----
    assign acc_nxt = sat_add(acc, out_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            tile_nnz  <= '0;
            tile_done <= 1'b0;
        end else begin
            tile_done <= 1'b0;
            if (out_fire) begin
                if (out_last) begin
                    tile_nnz  <= acc_nxt;
                    tile_done <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc <= acc_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_sparse_idx_gen.sv
module tb_sparse_idx_gen;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_last, out_ready;
    logic [7:0]  in_mask;

    logic        in_ready, out_valid, out_last, tile_done;
    logic [23:0] out_idx;
    logic [7:0]  out_lane_vld;
    logic [3:0]  out_cnt;
    logic [15:0] tile_nnz;

    logic        in_ready4, out_valid4, out_last4, tile_done4;
    logic [23:0] out_idx4;
    logic [7:0]  out_lane_vld4;
    logic [3:0]  out_cnt4;
    logic [3:0]  tile_nnz4;

    always #5 clk = ~clk;

    sparse_idx_gen dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mask(in_mask), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_lane_vld(out_lane_vld),
        .out_cnt(out_cnt), .out_last(out_last), .tile_nnz(tile_nnz),
        .tile_done(tile_done)
    );

    sparse_idx_gen #(.DW_NNZ(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_mask(in_mask), .in_last(in_last), .out_valid(out_valid4),
        .out_ready(out_ready), .out_idx(out_idx4), .out_lane_vld(out_lane_vld4),
        .out_cnt(out_cnt4), .out_last(out_last4), .tile_nnz(tile_nnz4),
        .tile_done(tile_done4)
    );

    typedef struct {
        logic [23:0] idx;
        logic [7:0]  vld;
        logic [3:0]  cnt;
        logic        last;
    } beat_t;

    typedef struct {
        int          cyc;
        logic [15:0] nnz;
        logic [3:0]  nnz4;
    } tile_t;

    typedef struct {
        logic [7:0]  m;
        logic        l;
        logic [23:0] idx;
        logic [7:0]  vld;
        logic [3:0]  cnt;
    } vec_t;

    beat_t beat_q[$];
    tile_t tile_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            beat_q.push_back('{out_idx, out_lane_vld, out_cnt, out_last});
        if (rst_n && tile_done)
            tile_q.push_back('{cyc, tile_nnz, tile_nnz4});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        beat_q.delete();
        tile_q.delete();
    endtask

    task automatic send(input logic [7:0] m, input logic l);
        bit ok = 0;
        int b  = 0;
        in_valid = 1'b1;
        in_mask  = m;
        in_last  = l;
        while (!ok && b < 50) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            b++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: mask 0x%0h never accepted", m);
        end
    endtask

    task automatic wait_beats(input int n);
        int b = 0;
        while (beat_q.size() < n && b < 100) begin
            tick();
            b++;
        end
        check("beat_count", beat_q.size(), n);
    endtask

    task automatic wait_tiles(input int n);
        int b = 0;
        while (tile_q.size() < n && b < 100) begin
            tick();
            b++;
        end
        check("tile_count", tile_q.size(), n);
    endtask

    task automatic check_beat(input int k, input logic [23:0] idx, input logic [7:0] vld,
                              input logic [3:0] cnt, input logic last);
        if (beat_q.size() > k) begin
            check($sformatf("beat%0d_idx", k),  beat_q[k].idx,  idx);
            check($sformatf("beat%0d_vld", k),  beat_q[k].vld,  vld);
            check($sformatf("beat%0d_cnt", k),  beat_q[k].cnt,  cnt);
            check($sformatf("beat%0d_last", k), beat_q[k].last, last);
        end
    endtask

    vec_t       tbl[8];
    logic [7:0] bp[4];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mask   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  0);
        check("rst_tile_nnz",  tile_nnz,  0);
        check("rst_tile_done", tile_done, 0);
        check("rst_out_idx",   out_idx,   0);
        check("rst_out_vld",   out_lane_vld, 0);
        check("rst_out_cnt",   out_cnt,   0);
        check("rst_out_last",  out_last,  0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Two-cycle latency with a single mask
        send(8'hA4, 1'b0);
        check("lat_t1_valid", out_valid, 0);
        tick();
        check("lat_t2_valid", out_valid, 1);
        check("lat_idx",      out_idx,   24'h0001EA);
        check("lat_vld",      out_lane_vld, 8'h07);
        check("lat_cnt",      out_cnt,   3);

        // Table-driven streaming with tile boundaries
        do_reset();
        tbl[0] = '{8'hFF, 1'b0, 24'hFAC688, 8'hFF, 4'd8};
        tbl[1] = '{8'h00, 1'b0, 24'h000000, 8'h00, 4'd0};
        tbl[2] = '{8'h81, 1'b1, 24'h000038, 8'h03, 4'd2};
        tbl[3] = '{8'h80, 1'b0, 24'h000007, 8'h01, 4'd1};
        tbl[4] = '{8'h55, 1'b1, 24'h000D10, 8'h0F, 4'd4};
        tbl[5] = '{8'h3C, 1'b0, 24'h000B1A, 8'h0F, 4'd4};
        tbl[6] = '{8'hA4, 1'b0, 24'h0001EA, 8'h07, 4'd3};
        tbl[7] = '{8'h01, 1'b1, 24'h000000, 8'h01, 4'd1};
        for (int k = 0; k < 8; k++)
            send(tbl[k].m, tbl[k].l);
        wait_beats(8);
        for (int k = 0; k < 8; k++)
            check_beat(k, tbl[k].idx, tbl[k].vld, tbl[k].cnt, tbl[k].l);
        wait_tiles(3);
        if (tile_q.size() >= 3) begin
            check("tbl_tile0", tile_q[0].nnz, 10);
            check("tbl_tile1", tile_q[1].nnz, 5);
            check("tbl_tile2", tile_q[2].nnz, 8);
        end

        // Backpressure: consumer stalled for 5 cycles while 4 masks are offered
        do_reset();
        bp[0] = 8'h11; bp[1] = 8'h22; bp[2] = 8'h44; bp[3] = 8'h88;
        begin
            int  k = 0;
            int  b = 0;
            bit  r;
            out_ready = 1'b0;
            in_last   = 1'b0;
            for (int c = 0; c < 5; c++) begin
                in_valid = (k < 4);
                in_mask  = bp[k & 3];
                @(negedge clk);
                r = in_ready && in_valid;
                tick();
                if (r) k++;
                if (out_valid)
                    check("bp_hold_idx", out_idx, 24'h000020);
            end
            check("bp_accepted",  k, 2);
            check("bp_in_ready",  in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_cnt",   out_cnt, 2);
            check("bp_no_beats",  beat_q.size(), 0);
            out_ready = 1'b1;
            while (k < 4 && b < 50) begin
                in_valid = 1'b1;
                in_mask  = bp[k];
                @(negedge clk);
                r = in_ready;
                tick();
                if (r) k++;
                b++;
            end
            in_valid = 1'b0;
            check("bp_all_accepted", k, 4);
        end
        wait_beats(4);
        check_beat(0, 24'h000020, 8'h03, 4'd2, 1'b0);
        check_beat(1, 24'h000029, 8'h03, 4'd2, 1'b0);
        check_beat(2, 24'h000032, 8'h03, 4'd2, 1'b0);
        check_beat(3, 24'h00003B, 8'h03, 4'd2, 1'b0);

        // Tile totals, back-to-back last beats, one-cycle pulse
        do_reset();
        send(8'h0F, 1'b0);
        send(8'h03, 1'b0);
        send(8'h01, 1'b1);
        send(8'hFF, 1'b1);
        wait_tiles(2);
        if (tile_q.size() >= 2) begin
            check("tile_a_nnz", tile_q[0].nnz, 7);
            check("tile_b_nnz", tile_q[1].nnz, 8);
            check("tile_b2b_gap", tile_q[1].cyc - tile_q[0].cyc, 1);
        end
        check("tile_done_low", tile_done, 0);
        tick();
        tick();
        check("tile_pulse_count", tile_q.size(), 2);
        check("tile_nnz_hold", tile_nnz, 8);

        // Saturation of a 4-bit counter
        do_reset();
        for (int k = 0; k < 4; k++)
            send(8'hFF, 1'b0);
        send(8'h01, 1'b1);
        wait_tiles(1);
        if (tile_q.size() >= 1) begin
            check("sat_nnz4",  tile_q[0].nnz4, 15);
            check("sat_nnz16", tile_q[0].nnz,  33);
        end

        // Reset with both stages full discards beats and partial tile
        do_reset();
        send(8'h0F, 1'b0);
        wait_beats(1);
        out_ready = 1'b0;
        send(8'h03, 1'b0);
        send(8'h07, 1'b0);
        check("mid_full_valid", out_valid, 1);
        check("mid_full_ready", in_ready, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rst_valid",     out_valid, 0);
        check("mid_rst_tile_done", tile_done, 0);
        check("mid_rst_in_ready",  in_ready, 1);
        out_ready = 1'b1;
        tick();
        check("mid_no_tile", tile_q.size(), 0);
        send(8'h01, 1'b1);
        wait_tiles(1);
        if (tile_q.size() >= 1) begin
            check("mid_post_nnz",  tile_q[0].nnz,  1);
            check("mid_post_nnz4", tile_q[0].nnz4, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
